// File: rtl/de_fetchalign.sv
// Fetch-to-decode aligner: buffers 64-bit fetch words as halfwords and presents
// 16/32/64-bit instructions left-aligned with their PC.
module de_fetchalign (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [63:0] flush_pc_i,
    input  logic [63:0] fetch_data_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    output logic [63:0] instr_o,
    output logic [1:0]  instr_len_o,
    output logic [63:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    // Buffer is kept flat with the head halfword in [127:112]; slots past cnt are always zero.
    logic [127:0] buf_q, buf_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [1:0]   skip_q, skip_d;
    logic [63:0]  pc_q, pc_d;

    logic [15:0]  head;
    logic [3:0]   need;
    logic [63:0]  instr_mask;
    logic         consume, accept;
    logic [3:0]   cnt_sh;
    logic [127:0] buf_sh;
    logic [63:0]  fetch_sh;

    always_comb begin
        head = buf_q[127:112];
        if (!head[15]) begin
            instr_len_o = 2'd0;
            need        = 4'd1;
            instr_mask  = 64'hFFFF_0000_0000_0000;
        end else if (!head[14]) begin
            instr_len_o = 2'd1;
            need        = 4'd2;
            instr_mask  = 64'hFFFF_FFFF_0000_0000;
        end else begin
            instr_len_o = 2'd2;
            need        = 4'd4;
            instr_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        instr_o       = buf_q[127:64] & instr_mask;
        instr_pc_o    = pc_q;
        instr_valid_o = (cnt_q >= need) && !flush_i;
        fetch_ready_o = !flush_i && (cnt_q <= 4'd4);
    end

    always_comb begin
        consume  = instr_valid_o && instr_ready_i;
        accept   = fetch_valid_i && fetch_ready_o;
        buf_sh   = consume ? (buf_q << {need, 4'b0000}) : buf_q;
        cnt_sh   = consume ? (cnt_q - need) : cnt_q;
        // Drop the leading halfwords before an unaligned redirect target.
        fetch_sh = fetch_data_i << {skip_q, 4'b0000};

        buf_d  = buf_sh;
        cnt_d  = cnt_sh;
        skip_d = skip_q;
        pc_d   = consume ? (pc_q + {59'b0, need, 1'b0}) : pc_q;

        if (accept) begin
            buf_d  = buf_sh | ({fetch_sh, 64'b0} >> {cnt_sh, 4'b0000});
            cnt_d  = cnt_sh + 4'd4 - {2'b00, skip_q};
            skip_d = 2'd0;
        end

        if (flush_i) begin
            buf_d  = '0;
            cnt_d  = 4'd0;
            pc_d   = {flush_pc_i[63:1], 1'b0};
            skip_d = flush_pc_i[2:1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q  <= '0;
            cnt_q  <= 4'd0;
            skip_q <= 2'd0;
            pc_q   <= 64'd0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            skip_q <= skip_d;
            pc_q   <= pc_d;
        end
    end

endmodule

// File: tb/tb_de_fetchalign.sv
// Directed bench for de_fetchalign: hand-computed instruction, length and PC sequences.
module tb_de_fetchalign;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [63:0] flush_pc_i;
    logic [63:0] fetch_data_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [63:0] instr_o;
    logic [1:0]  instr_len_o;
    logic [63:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    int checks = 0;
    int errors = 0;

    de_fetchalign dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .fetch_data_i  (fetch_data_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .instr_o       (instr_o),
        .instr_len_o   (instr_len_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_instr(input string tag, input logic [63:0] ins, input logic [1:0] len,
                                input logic [63:0] pc);
        check({tag, "_valid"}, {63'b0, instr_valid_o}, 64'd1);
        check({tag, "_instr"}, instr_o, ins);
        check({tag, "_len"}, {62'b0, instr_len_o}, {62'b0, len});
        check({tag, "_pc"}, instr_pc_o, pc);
    endtask

    task automatic do_flush(input logic [63:0] target);
        flush_i    = 1'b1;
        flush_pc_i = target;
        #1;
        check("flush_valid", {63'b0, instr_valid_o}, 64'd0);
        check("flush_ready", {63'b0, fetch_ready_o}, 64'd0);
        step();
        flush_i = 1'b0;
        #1;
        check("post_flush_valid", {63'b0, instr_valid_o}, 64'd0);
        check("post_flush_pc", instr_pc_o, {target[63:1], 1'b0});
        check("post_flush_fready", {63'b0, fetch_ready_o}, 64'd1);
    endtask

    task automatic feed(input logic [63:0] word);
        fetch_data_i  = word;
        fetch_valid_i = 1'b1;
        step();
        fetch_valid_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        flush_i       = 1'b0;
        flush_pc_i    = 64'd0;
        fetch_data_i  = 64'd0;
        fetch_valid_i = 1'b0;
        instr_ready_i = 1'b0;
        step();
        check("rst_valid", {63'b0, instr_valid_o}, 64'd0);
        check("rst_instr", instr_o, 64'd0);
        check("rst_len", {62'b0, instr_len_o}, 64'd0);
        check("rst_pc", instr_pc_o, 64'd0);
        check("rst_fready", {63'b0, fetch_ready_o}, 64'd1);
        rst_i = 1'b0;
        step();

        // Four 16-bit ops from one word.
        instr_ready_i = 1'b1;
        feed(64'h0001_0002_0003_0004);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] e;
            e = {16'(i + 1), 48'b0};
            expect_instr($sformatf("t1_%0d", i), e, 2'd0, 64'(2 * i));
            step();
        end
        check("t1_empty", {63'b0, instr_valid_o}, 64'd0);
        check("t1_pc_end", instr_pc_o, 64'd8);

        // 64-bit instruction straddling two words.
        do_flush(64'd0);
        feed(64'h0001_0002_C123_4567);
        expect_instr("t2_a", 64'h0001_0000_0000_0000, 2'd0, 64'd0);
        step();
        expect_instr("t2_b", 64'h0002_0000_0000_0000, 2'd0, 64'd2);
        step();
        check("t2_partial_valid", {63'b0, instr_valid_o}, 64'd0);
        check("t2_partial_len", {62'b0, instr_len_o}, 64'd2);
        step();
        check("t2_partial_valid2", {63'b0, instr_valid_o}, 64'd0);
        feed(64'h89AB_CDEF_0005_0006);
        expect_instr("t2_long", 64'hC123_4567_89AB_CDEF, 2'd2, 64'd4);
        step();
        expect_instr("t2_c", 64'h0005_0000_0000_0000, 2'd0, 64'hC);
        step();
        expect_instr("t2_d", 64'h0006_0000_0000_0000, 2'd0, 64'hE);
        step();
        check("t2_empty", {63'b0, instr_valid_o}, 64'd0);

        // Flush to an unaligned target: only halfword 3 of the first word survives.
        do_flush(64'h1006);
        feed(64'h1111_2222_3333_8444);
        check("t3_partial_valid", {63'b0, instr_valid_o}, 64'd0);
        check("t3_partial_len", {62'b0, instr_len_o}, 64'd1);
        feed(64'h5555_6666_7777_0001);
        expect_instr("t3_a", 64'h8444_5555_0000_0000, 2'd1, 64'h1006);
        step();
        expect_instr("t3_b", 64'h6666_0000_0000_0000, 2'd0, 64'h100A);
        step();
        expect_instr("t3_c", 64'h7777_0000_0000_0000, 2'd0, 64'h100C);
        step();
        expect_instr("t3_d", 64'h0001_0000_0000_0000, 2'd0, 64'h100E);
        step();
        check("t3_empty", {63'b0, instr_valid_o}, 64'd0);

        // Backpressure until full, then release.
        do_flush(64'h2000);
        instr_ready_i = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_data_i  = 64'h0001_0002_0003_0004;
        step();
        check("t4_fready_4", {63'b0, fetch_ready_o}, 64'd1);
        fetch_data_i = 64'h0005_0006_0007_0008;
        step();
        fetch_data_i = 64'h0009_000A_000B_000C;
        check("t4_fready_full", {63'b0, fetch_ready_o}, 64'd0);
        step();
        check("t4_fready_full2", {63'b0, fetch_ready_o}, 64'd0);
        expect_instr("t4_stalled", 64'h0001_0000_0000_0000, 2'd0, 64'h2000);
        fetch_valid_i = 1'b0;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] e;
            e = {16'(i + 1), 48'b0};
            expect_instr($sformatf("t4_%0d", i), e, 2'd0, 64'h2000 + 64'(2 * i));
            step();
        end
        check("t4_empty", {63'b0, instr_valid_o}, 64'd0);

        // Flush while stalled and full, to a target near the top of the address space.
        instr_ready_i = 1'b0;
        feed(64'h0001_0002_0003_0004);
        feed(64'h0005_0006_0007_0008);
        check("t5_full_fready", {63'b0, fetch_ready_o}, 64'd0);
        check("t5_full_valid", {63'b0, instr_valid_o}, 64'd1);
        do_flush(64'hFFFF_FFFF_FFFF_FFFC);
        instr_ready_i = 1'b1;
        feed(64'h0000_0000_0011_0022);
        expect_instr("t6_a", 64'h0011_0000_0000_0000, 2'd0, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        expect_instr("t6_b", 64'h0022_0000_0000_0000, 2'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("t6_wrap_pc", instr_pc_o, 64'd0);
        check("t6_empty", {63'b0, instr_valid_o}, 64'd0);

        // Asynchronous reset mid-operation.
        instr_ready_i = 1'b0;
        feed(64'hC000_0001_0002_0003);
        check("t7_pre_valid", {63'b0, instr_valid_o}, 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("t7_rst_valid", {63'b0, instr_valid_o}, 64'd0);
        check("t7_rst_instr", instr_o, 64'd0);
        check("t7_rst_pc", instr_pc_o, 64'd0);
        step();
        rst_i = 1'b0;
        step();
        check("t7_after_valid", {63'b0, instr_valid_o}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/de_fetchalign.md
# de_fetchAlign

Instruction aligner between the fetch unit and the decode stage. It accepts 64-bit fetch words, buffers them as 16-bit halfwords, and splits them into variable-length instructions of 16, 32 or 64 bits. Each instruction is presented left-aligned in a 64-bit word, so the bad-opcode detector and the rest of decode can inspect bits [63:56] directly. It also tracks the PC of each presented instruction and handles redirects (flush) to any halfword-aligned address.

## Interface
- No parameters. Buffer depth is fixed at 8 halfwords (128 bits).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  redirect; empties the buffer and loads a new PC.
- flush_pc  in  64  redirect target; bit 0 ignored.
- fetch_data  in  64  fetch word. The lowest-address halfword is in [63:48], the highest in [15:0].
- fetch_valid  in  1  fetch_data valid.
- fetch_ready  out  1  block can accept a fetch word this cycle.
- instr  out  64  instruction, left-aligned. Bits beyond the instruction length are 0.
- instr_len  out  2  0 = 16-bit, 1 = 32-bit, 2 = 64-bit. The value 3 never occurs.
- instr_pc  out  64  byte address of the instruction.
- instr_valid  out  1  instr, instr_len and instr_pc are valid.
- instr_ready  in  1  decode consumes the instruction this cycle.

## Operation
- **State**
  - buf: 8×16-bit halfwords; head is buf[0].
  - cnt: 0–8 valid halfwords.
  - skip: 0–3 halfwords to drop from the next fetch word.
  - pc: 64 bits.
- **Length decode from head halfword h**
  - h[15] = 0: 1 halfword.
  - h[15:14] = 2'b10: 2 halfwords.
  - h[15:14] = 2'b11: 4 halfwords.
- **Outputs**
  - need = decoded halfword count.
  - instr_valid = (cnt >= need) & ~flush.
  - instr = {buf[0..need-1], zero fill}.
  - instr_pc = pc.
  - All outputs are combinational from registered state plus flush.
- **fetch_ready** = ~flush & (cnt <= 4). It does not depend on instr_ready in the same cycle.
- **Consume (instr_valid & instr_ready)**
  - Shift buf left by need.
  - cnt -= need.
  - pc += 2·need, wrapping mod 2^64.
- **Accept (fetch_valid & fetch_ready)**
  - Append halfwords skip..3 of fetch_data at position cnt, counted after any same-cycle consume.
  - cnt += 4 − skip.
  - skip <= 0.
- **Simultaneous consume and accept**: the shift is applied first, then the append, in one edge. cnt never exceeds 8.
- **Flush** has the highest priority in its cycle:
  - cnt <= 0, buf <= 0.
  - pc <= {flush_pc[63:1], 1'b0}.
  - skip <= flush_pc[2:1].
  - No consume or accept occurs that cycle: instr_valid = 0 and fetch_ready = 0.
- The block performs no opcode legality checks. Illegal encodings pass through for downstream detection.
- **Partial instruction**: when cnt < need (e.g. a 64-bit instruction straddling two fetch words), instr_valid stays 0 until enough halfwords arrive.

## Timing
- **Reset values**
  - cnt = 0, skip = 0, pc = 0, buf = 0.
  - Outputs: instr_valid = 0, instr = 0, instr_len = 0, instr_pc = 0.
  - fetch_ready = 1 when flush = 0.
- **Latency**
  - A fetch word accepted at edge N makes its first instruction visible from edge N (registered buffer), i.e. in cycle N+1. This holds only if the instruction is complete at that point.
  - Peak throughput is one instruction per cycle.
  - Fetch throughput is one word per cycle while cnt ≤ 4.
- **Reset mid-operation** clears all state immediately; no partial instruction survives.
- **Flush during a stalled instruction** (instr_valid = 1, instr_ready = 0) discards that instruction.
- **Buffer boundaries**
  - At cnt = 8, fetch_ready = 0.
  - At cnt = 0, instr_valid = 0.

## Test plan
- **Reset, then a word of four 16-bit ops**
  - Stimulus: fetch 64'h0001_0002_0003_0004, instr_ready held high.
  - Required: four cycles with instr = 0001…, 0002…, 0003…, 0004… (upper halfword, rest 0).
  - Required: instr_pc = 0, 2, 4, 6.
- **64-bit instruction straddling two words**
  - Stimulus: word 64'h0001_0002_C123_4567, then word 64'h89AB_CDEF_0005_0006.
  - Required: after the 16-bit ops, instr = 64'hC123_4567_89AB_CDEF, instr_len = 2, instr_pc = 4.
  - Required: instr_valid is low until the second word is accepted.
- **Flush to an unaligned target**
  - Stimulus: flush_pc = 64'h1006, then fetch 64'h1111_2222_3333_8444_5555 layout with halfword 3 = 16'h8444 and the following word's halfword 0 = 16'h5555.
  - Required: the first output is the 32-bit instruction 64'h8444_5555_0000_0000 with instr_pc = 64'h1006.
- **Backpressure**
  - Stimulus: instr_ready = 0, fetch_valid continuously high.
  - Required: cnt reaches 8, fetch_ready = 0, and no data loss.
  - Required: on releasing instr_ready, the instruction order and pcs are unchanged.
- **Flush while stalled and full**
  - Required: in the flush cycle, instr_valid = 0 and fetch_ready = 0.
  - Required: in the next cycle, cnt = 0 and instr_pc = the new target.
- **PC wrap**
  - Stimulus: flush_pc = 64'hFFFF_FFFF_FFFF_FFFC, then two 16-bit ops.
  - Required: instr_pc = …FFFC, then …FFFE, then 0.
